// File: rtl/therm_pkg.sv
// Shared helpers for the unary DAC thermometer path: element count and the
// pointer wrap arithmetic. Also used by bench models of the ADC decoder.
package therm_pkg;

  // Number of unit elements driven by a b-bit code.
  function automatic int n_elem(input int b);
    return (1 << b) - 1;
  endfunction

  // (p + c) mod N for p in 0..N-1 and c in 0..N; a single conditional
  // subtract is enough because the sum never reaches 2N.
  function automatic int mod_add(input int p, input int c, input int b);
    int s;
    s = p + c;
    if (s >= n_elem(b)) s = s - n_elem(b);
    return s;
  endfunction

endpackage

// File: rtl/therm_rotate.sv
// Registered circular left-rotate of an N-bit element vector by rot.
// The log2 barrel is split over two register stages: the low rot bits are
// applied before the first register, the high bits before the second.
module therm_rotate import therm_pkg::*; #(
  parameter int b = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [n_elem(b)-1:0]   vec,
  input  logic [b-1:0]           rot,
  input  logic                   vec_vld,
  output logic [n_elem(b)-1:0]   rotated,
  output logic                   rotated_vld
);

  localparam int N  = n_elem(b);
  localparam int LO = b / 2;

  logic [N-1:0]    lo_rot;
  logic [N-1:0]    hi_rot;
  logic [N-1:0]    vec_p2;
  logic [b-LO-1:0] hi_p2;
  logic            vld_p2;

  // Moves element k to position (k + s) mod N.
  function automatic logic [N-1:0] rotl(input logic [N-1:0] v, input int s);
    logic [N-1:0] o;
    o = '0;
    for (int k = 0; k < N; k++) o[(k + s) % N] = v[k];
    return o;
  endfunction

  // Barrel stages driven by the low rotation bits.
  always_comb begin
    lo_rot = vec;
    for (int j = 0; j < LO; j++)
      if (rot[j]) lo_rot = rotl(lo_rot, 1 << j);
  end

  // ---- stage boundary: partial rotation ----
  // Hold the partly rotated vector and the rotation bits still to apply.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vec_p2 <= '0;
      hi_p2  <= '0;
      vld_p2 <= 1'b0;
    end else begin
      vec_p2 <= lo_rot;
      hi_p2  <= rot[b-1:LO];
      vld_p2 <= vec_vld;
    end
  end

  // Barrel stages driven by the high rotation bits.
  always_comb begin
    hi_rot = vec_p2;
    for (int j = LO; j < b; j++)
      if (hi_p2[j-LO]) hi_rot = rotl(hi_rot, 1 << j);
  end

  // ---- stage boundary: element enables ----
  // Idle samples leave every element off.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rotated     <= '0;
      rotated_vld <= 1'b0;
    end else begin
      rotated     <= vld_p2 ? hi_rot : '0;
      rotated_vld <= vld_p2;
    end
  end

endmodule

// File: rtl/bin2therm_dwa_pipeline.sv
// Pipelined binary-to-thermometer encoder with optional data-weighted
// averaging. A b-bit code enables that many of the N unit elements; with
// DWA the enabled window starts at a running pointer so every element is
// used equally often. The rotation for each sample is captured with it, so
// later pointer moves never disturb samples already in flight.
module bin2therm_dwa_pipeline import therm_pkg::*; #(
  parameter int b      = 8,
  parameter bit DWA_EN = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 valid,
  input  logic [b-1:0]         bin,
  input  logic                 ptr_clr,
  output logic [n_elem(b)-1:0] thermo,
  output logic                 thermo_vld,
  output logic [b-1:0]         ptr
);

  localparam int N  = n_elem(b);
  localparam int PW = b;

  logic [b-1:0] code_p0;
  logic         vld_p0;
  logic         clr_p0;
  logic [N-1:0] base;
  logic [b-1:0] r_sel;
  logic [b-1:0] ptr_nxt;
  logic [N-1:0] t_p1;
  logic [b-1:0] r_p1;
  logic         vld_p1;

  // ---- stage boundary: input register ----
  // Capture code, qualifier and pointer clear together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      code_p0 <= '0;
      vld_p0  <= 1'b0;
      clr_p0  <= 1'b0;
    end else begin
      code_p0 <= bin;
      vld_p0  <= valid;
      clr_p0  <= ptr_clr;
    end
  end

  // Plain thermometer: the lowest code_p0 elements on, all off when idle.
  always_comb begin
    base = '0;
    for (int k = 0; k < N; k++) base[k] = vld_p0 && (k < int'(code_p0));
  end

  // Rotation source for the sample in S1 and the pointer it leaves behind.
  // A clear forces this sample to rotate by 0 but still lets it advance ptr.
  always_comb begin
    r_sel   = '0;
    ptr_nxt = '0;
    if (DWA_EN) begin
      r_sel   = clr_p0 ? '0 : ptr;
      ptr_nxt = ptr;
      if (vld_p0)      ptr_nxt = PW'(mod_add(int'(r_sel), int'(code_p0), b));
      else if (clr_p0) ptr_nxt = '0;
    end
  end

  // DWA pointer register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ptr <= '0;
    else        ptr <= ptr_nxt;
  end

  // ---- stage boundary: decode ----
  // Hold the base pattern with the rotation captured for this sample.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      t_p1   <= '0;
      r_p1   <= '0;
      vld_p1 <= 1'b0;
    end else begin
      if (vld_p0) assert ($countones(base) == int'(code_p0));
      t_p1   <= base;
      r_p1   <= r_sel;
      vld_p1 <= vld_p0;
    end
  end

  // ---- stage boundary: rotate and drive elements ----
  therm_rotate #(.b(b)) u_rotate (
    .clock       (clock),
    .reset       (reset),
    .vec         (t_p1),
    .rot         (r_p1),
    .vec_vld     (vld_p1),
    .rotated     (thermo),
    .rotated_vld (thermo_vld)
  );

endmodule

// File: tb/tb_bin2therm_dwa_pipeline.sv
// Directed bench for bin2therm_dwa_pipeline at b=4 (N=15): one instance with
// DWA rotation, one with it bypassed, plus a short modelled random run.
module tb_bin2therm_dwa_pipeline;
  import therm_pkg::*;

  localparam int B = 4;
  localparam int N = 15;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid_a, ptr_clr_a, valid_z, ptr_clr_z;
  logic [3:0]  bin_a, bin_z, ptr_a, ptr_z;
  logic [14:0] thermo_a, thermo_z;
  logic        thermo_vld_a, thermo_vld_z;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [14:0] th;
    logic        v;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   pm, pexp, code, r;
  logic v, c;

  always #5 clock = ~clock;

  bin2therm_dwa_pipeline #(.b(B), .DWA_EN(1'b1)) dut_a (
    .clock      (clock),
    .reset      (reset),
    .valid      (valid_a),
    .bin        (bin_a),
    .ptr_clr    (ptr_clr_a),
    .thermo     (thermo_a),
    .thermo_vld (thermo_vld_a),
    .ptr        (ptr_a)
  );

  bin2therm_dwa_pipeline #(.b(B), .DWA_EN(1'b0)) dut_z (
    .clock      (clock),
    .reset      (reset),
    .valid      (valid_z),
    .bin        (bin_z),
    .ptr_clr    (ptr_clr_z),
    .thermo     (thermo_z),
    .thermo_vld (thermo_vld_z),
    .ptr        (ptr_z)
  );

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: elements (k + rr) mod N for k < cd are on.
  function automatic logic [14:0] exp_therm(input int cd, input int rr);
    logic [14:0] o;
    o = '0;
    for (int k = 0; k < cd; k++) o[(k + rr) % N] = 1'b1;
    return o;
  endfunction

  initial begin
    reset = 1'b0;
    valid_a = 1'b0; bin_a = '0; ptr_clr_a = 1'b0;
    valid_z = 1'b0; bin_z = '0; ptr_clr_z = 1'b0;
    cyc(); cyc();
    chk("rst_thermo_a", thermo_a, 0);
    chk("rst_vld_a", thermo_vld_a, 0);
    chk("rst_ptr_a", ptr_a, 0);
    chk("rst_thermo_z", thermo_z, 0);
    reset = 1'b1;
    cyc();

    // DWA codes 5,5,5 alongside bypass codes 0,1,7,15
    valid_a = 1'b1; bin_a = 4'd5; valid_z = 1'b1; bin_z = 4'd0; cyc();
    bin_z = 4'd1; cyc();
    chk("dwa_ptr5", ptr_a, 5);
    bin_z = 4'd7; ptr_clr_z = 1'b1; cyc();
    chk("dwa_ptr10", ptr_a, 10);
    bin_z = 4'd15; ptr_clr_z = 1'b0; valid_a = 1'b0; cyc();
    chk("dwa_ptr_wrap0", ptr_a, 0);
    chk("dwa_th_1f", thermo_a, 15'h001F);
    chk("dwa_vld0", thermo_vld_a, 1);
    chk("byp_th_code0", thermo_z, 15'h0000);
    chk("byp_vld_code0", thermo_vld_z, 1);
    valid_z = 1'b0; cyc();
    chk("dwa_th_3e0", thermo_a, 15'h03E0);
    chk("byp_th_code1", thermo_z, 15'h0001);
    chk("byp_vld_code1", thermo_vld_z, 1);
    chk("byp_ptr_hold", ptr_z, 0);
    cyc();
    chk("dwa_th_7c00", thermo_a, 15'h7C00);
    chk("byp_th_code7", thermo_z, 15'h007F);
    chk("byp_vld_code7", thermo_vld_z, 1);
    cyc();
    chk("dwa_idle_th", thermo_a, 0);
    chk("dwa_idle_vld", thermo_vld_a, 0);
    chk("byp_th_code15", thermo_z, 15'h7FFF);
    chk("byp_vld_code15", thermo_vld_z, 1);
    chk("byp_ptr_still0", ptr_z, 0);
    cyc();
    chk("byp_idle_vld", thermo_vld_z, 0);
    chk("byp_idle_th", thermo_z, 0);

    // Wrap split: ptr=12 then code 6
    valid_a = 1'b1; bin_a = 4'd12; cyc();
    bin_a = 4'd6; cyc();
    chk("wrap_ptr12", ptr_a, 12);
    valid_a = 1'b0; cyc();
    chk("wrap_ptr3", ptr_a, 3);
    cyc();
    chk("wrap_th_fff", thermo_a, 15'h0FFF);
    cyc();
    chk("wrap_th_7007", thermo_a, 15'h7007);

    // ptr_clr with a valid sample, then ptr_clr alone
    valid_a = 1'b1; bin_a = 4'd6; cyc();
    bin_a = 4'd4; ptr_clr_a = 1'b1; cyc();
    chk("clr_ptr9", ptr_a, 9);
    valid_a = 1'b0; ptr_clr_a = 1'b0; cyc();
    chk("clr_ptr_code4", ptr_a, 4);
    cyc();
    chk("clr_th_1f8", thermo_a, 15'h01F8);
    cyc();
    chk("clr_th_unrot", thermo_a, 15'h000F);
    ptr_clr_a = 1'b1; cyc();
    chk("clr_alone_pending", ptr_a, 4);
    ptr_clr_a = 1'b0; cyc();
    chk("clr_alone_ptr0", ptr_a, 0);

    // Code boundaries N and 0 at a non-zero pointer
    valid_a = 1'b1; bin_a = 4'd4; cyc();
    bin_a = 4'd15; cyc();
    chk("bnd_ptr4", ptr_a, 4);
    bin_a = 4'd0; cyc();
    chk("bnd_ptr_codeN", ptr_a, 4);
    valid_a = 1'b0; cyc();
    chk("bnd_ptr_code0", ptr_a, 4);
    chk("bnd_th_f", thermo_a, 15'h000F);
    cyc();
    chk("bnd_th_all", thermo_a, 15'h7FFF);
    chk("bnd_vld_all", thermo_vld_a, 1);
    cyc();
    chk("bnd_th_none", thermo_a, 0);
    chk("bnd_vld_none", thermo_vld_a, 1);
    cyc();
    chk("bnd_vld_idle", thermo_vld_a, 0);

    // Reset asserted mid-stream with valid high
    valid_a = 1'b1; bin_a = 4'd7; cyc(); cyc(); cyc(); cyc();
    chk("mid_th_pre", thermo_a, 15'h07F0);
    chk("mid_ptr_pre", ptr_a, 10);
    reset = 1'b0; #1;
    chk("mid_rst_th", thermo_a, 0);
    chk("mid_rst_vld", thermo_vld_a, 0);
    chk("mid_rst_ptr", ptr_a, 0);
    cyc(); cyc();
    chk("mid_rst_hold_vld", thermo_vld_a, 0);
    bin_a = 4'd3; reset = 1'b1; cyc();
    valid_a = 1'b0; cyc();
    chk("post_rst_ptr3", ptr_a, 3);
    cyc();
    chk("post_rst_no_partial", thermo_vld_a, 0);
    chk("post_rst_th_zero", thermo_a, 0);
    cyc();
    chk("post_rst_th_7", thermo_a, 15'h0007);
    chk("post_rst_vld", thermo_vld_a, 1);
    cyc();

    // Modelled run with random gaps and occasional pointer clears
    pm = 3;
    e.th = '0; e.v = 1'b0;
    q.push_back(e); q.push_back(e); q.push_back(e);
    for (int i = 0; i < 60; i++) begin
      v    = ($urandom_range(0, 3) != 0);
      c    = ($urandom_range(0, 9) == 0);
      code = $urandom_range(0, 15);
      valid_a = v; bin_a = code[3:0]; ptr_clr_a = c;
      pexp = pm;
      r    = c ? 0 : pm;
      if (v)      pm = mod_add(r, code, B);
      else if (c) pm = 0;
      e.v  = v;
      e.th = v ? exp_therm(code, r) : '0;
      q.push_back(e);
      cyc();
      e = q.pop_front();
      chk("rand_thermo", thermo_a, e.th);
      chk("rand_vld", thermo_vld_a, e.v);
      chk("rand_ptr", ptr_a, pexp);
    end
    valid_a = 1'b0; ptr_clr_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e.th = '0; e.v = 1'b0;
      q.push_back(e);
      cyc();
      e = q.pop_front();
      chk("drain_thermo", thermo_a, e.th);
      chk("drain_vld", thermo_vld_a, e.v);
    end
    chk("drain_ptr", ptr_a, pm);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
